// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front-end control block.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } sw_state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 16;

    // Width of a counter that must be able to hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_button_debounce.sv
// One push-button: 2-flop synchroniser, stable-count debouncer and rising-edge detector.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    // The edge that would make the count reach DEBOUNCE_CYCLES commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_level & ~r_level_d;

endmodule : button_debounce

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounces start/clear buttons and runs the IDLE/RUNNING/PAUSED FSM
// that produces the counter enable and a one-cycle clear pulse.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start_btn,
    input  logic      clear_btn,
    output logic      run,
    output logic      clr,
    output logic      paused,
    output sw_state_t state
);

    logic      w_start_level;
    logic      w_start_rise;
    logic      w_clear_level;
    logic      w_clear_rise;
    logic      w_unused_levels;

    sw_state_t r_state;
    sw_state_t w_state_nxt;
    logic      r_run;
    logic      r_clr;
    logic      r_paused;
    logic      w_clr_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(start_btn),
        .level  (w_start_level),
        .rise   (w_start_rise)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(clear_btn),
        .level  (w_clear_level),
        .rise   (w_clear_rise)
    );

    // Only the edge events drive the FSM; the debounced levels are not needed here.
    assign w_unused_levels = w_start_level ^ w_clear_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_run    <= 1'b0;
            r_clr    <= 1'b0;
            r_paused <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= (w_state_nxt == RUNNING);
            r_clr    <= w_clr_nxt;
            r_paused <= (w_state_nxt == PAUSED);
        end
    end

    // Clear outranks start outside RUNNING; while RUNNING clear is ignored entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_clear_rise) begin
                    w_clr_nxt = 1'b1;
                end else if (w_start_rise) begin
                    w_state_nxt = RUNNING;
                end
            end
            RUNNING: begin
                if (w_start_rise) begin
                    w_state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (w_clear_rise) begin
                    w_state_nxt = IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_start_rise) begin
                    w_state_nxt = RUNNING;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign run    = r_run;
    assign clr    = r_clr;
    assign paused = r_paused;
    assign state  = r_state;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic      clk;
    logic      reset;
    logic      start_btn;
    logic      clear_btn;
    logic      run;
    logic      clr;
    logic      paused;
    sw_state_t state;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_btn(start_btn),
        .clear_btn(clear_btn),
        .run      (run),
        .clr      (clr),
        .paused   (paused),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input sw_state_t st, input logic r,
                            input logic c, input logic p);
        chk({tag, ".state"},  8'(state),  8'(st));
        chk({tag, ".run"},    8'(run),    8'(r));
        chk({tag, ".clr"},    8'(clr),    8'(c));
        chk({tag, ".paused"}, 8'(paused), 8'(p));
    endtask

    initial begin
        reset     = 1'b0;
        start_btn = 1'b0;
        clear_btn = 1'b0;

        // 1: reset values, then a held start gives RUNNING at edge 7 and nothing more
        step(3);
        chk_outs("t1_reset", IDLE, 1'b0, 1'b0, 1'b0);
        reset     = 1'b1;
        start_btn = 1'b1;
        step(6);
        chk_outs("t1_edge6", IDLE, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_outs("t1_edge7", RUNNING, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("t1_hold.run", 8'(run), 8'd1);
            chk("t1_hold.clr", 8'(clr), 8'd0);
        end

        // 2: 3-cycle glitches with 1-cycle gaps never get through
        reset     = 1'b0;
        start_btn = 1'b0;
        step(2);
        chk_outs("t2_reset", IDLE, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_btn = 1'b1;
            step(3);
            start_btn = 1'b0;
            step(1);
            chk("t2_glitch.run", 8'(run), 8'd0);
        end
        step(10);
        chk_outs("t2_after", IDLE, 1'b0, 1'b0, 1'b0);

        // 3: IDLE -> RUNNING -> PAUSED -> IDLE with a single clr pulse
        start_btn = 1'b1;
        step(10);
        chk_outs("t3_run", RUNNING, 1'b1, 1'b0, 1'b0);
        start_btn = 1'b0;
        step(10);
        chk_outs("t3_run_rel", RUNNING, 1'b1, 1'b0, 1'b0);
        start_btn = 1'b1;
        step(10);
        chk_outs("t3_pause", PAUSED, 1'b0, 1'b0, 1'b1);
        start_btn = 1'b0;
        step(10);
        chk_outs("t3_pause_rel", PAUSED, 1'b0, 1'b0, 1'b1);
        clear_btn = 1'b1;
        step(6);
        chk_outs("t3_clr_edge6", PAUSED, 1'b0, 1'b0, 1'b1);
        step(1);
        chk_outs("t3_clr_edge7", IDLE, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_outs("t3_clr_edge8", IDLE, 1'b0, 1'b0, 1'b0);
        step(2);
        clear_btn = 1'b0;
        step(10);
        chk_outs("t3_idle", IDLE, 1'b0, 1'b0, 1'b0);

        // 4: clear ignored while running; simultaneous press in PAUSED clears
        start_btn = 1'b1;
        step(10);
        start_btn = 1'b0;
        step(10);
        chk_outs("t4_run", RUNNING, 1'b1, 1'b0, 1'b0);
        clear_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t4_clr_ign.clr", 8'(clr), 8'd0);
            chk("t4_clr_ign.run", 8'(run), 8'd1);
        end
        clear_btn = 1'b0;
        step(10);
        chk_outs("t4_still_run", RUNNING, 1'b1, 1'b0, 1'b0);
        start_btn = 1'b1;
        step(10);
        start_btn = 1'b0;
        step(10);
        chk_outs("t4_pause", PAUSED, 1'b0, 1'b0, 1'b1);
        start_btn = 1'b1;
        clear_btn = 1'b1;
        step(6);
        chk_outs("t4_both_edge6", PAUSED, 1'b0, 1'b0, 1'b1);
        step(1);
        chk_outs("t4_both_edge7", IDLE, 1'b0, 1'b1, 1'b0);
        step(1);
        chk_outs("t4_both_edge8", IDLE, 1'b0, 1'b0, 1'b0);
        step(10);
        chk_outs("t4_both_held", IDLE, 1'b0, 1'b0, 1'b0);
        start_btn = 1'b0;
        clear_btn = 1'b0;
        step(10);

        // 5: reset mid-debounce restarts the full latency from reset release
        start_btn = 1'b1;
        step(4);
        reset = 1'b0;
        #1;
        chk_outs("t5_in_reset", IDLE, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("t5_reset_edge.run", 8'(run), 8'd0);
        reset = 1'b1;
        step(6);
        chk_outs("t5_edge6", IDLE, 1'b0, 1'b0, 1'b0);
        step(1);
        chk_outs("t5_edge7", RUNNING, 1'b1, 1'b0, 1'b0);

        // 6: illegal encoding recovers to IDLE
        force dut.r_state = sw_state_t'(2'b11);
        step(1);
        chk("t6_forced.run",    8'(run),    8'd0);
        chk("t6_forced.paused", 8'(paused), 8'd0);
        chk("t6_forced.clr",    8'(clr),    8'd0);
        release dut.r_state;
        step(1);
        chk_outs("t6_recover", IDLE, 1'b0, 1'b0, 1'b0);
        step(5);
        chk_outs("t6_stay_idle", IDLE, 1'b0, 1'b0, 1'b0);
        start_btn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
